// File: rtl/uart_fifo.sv
// Memory-mapped UART with RX/TX FIFOs, programmable baud divisor, parity and 1/2 stop bits.
// Define UART_IRQ_EN to add the irq output and the IER register at index 4.

module uart_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push_s & ~flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; a flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module uart_fifo #(
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 694
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
`ifdef UART_IRQ_EN
  ,output logic       irq
`endif
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic parity_bit(input logic [7:0] d, input logic even);
    if (even) return ^d;
    else      return ~(^d);
  endfunction

  logic             mem_ready_r;
  logic [31:0]      mem_rdata_r;
  logic [31:0]      rdata_s;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       lcr_r;
  logic             tov_r, fe_r, pe_r, oe_r;
  logic [2:0]       idx_s;
  logic             accept_s, rd_s, wr_s;
  logic [7:0]       lsr_s, lvl_s;
  logic [8:0]       rx_cnt9_s, tx_cnt9_s;
  logic             unused_s;

  logic [7:0]       rx_head_s, tx_head_s;
  logic [RAW:0]     rx_count_s;
  logic [TAW:0]     tx_count_s;
  logic             rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
  logic             rx_pop_s, rx_push_s, rx_flush_s;
  logic             tx_pop_s, tx_push_s, tx_flush_s;

  logic [2:0]       tx_state_r, tx_bit_r;
  logic [DIV_W-1:0] tx_cnt_r, tx_div_r;
  logic [7:0]       tx_sh_r;
  logic             tx_par_en_r, tx_stop2_r, tx_par_r, tx_stop_sec_r, txd_r;
  logic             tx_end_s;

  logic             rxd_s1_r, rxd_s2_r, rxd_prev_r;
  logic [2:0]       rx_state_r, rx_bit_r;
  logic [DIV_W-1:0] rx_cnt_r, rx_div_r;
  logic [7:0]       rx_sh_r;
  logic             rx_par_en_r, rx_even_r, rx_par_bad_r;
  logic             rx_done_s, rx_good_s, fe_set_s, pe_set_s, oe_set_s, tov_set_s;

  assign idx_s    = mem_addr[4:2];
  assign accept_s = mem_valid & enable & ~mem_ready_r;
  assign rd_s     = accept_s & (mem_wstrb == 4'b0000);
  assign wr_s     = accept_s & mem_wstrb[0];
  assign unused_s = ^{mem_addr, mem_wdata, mem_wstrb};

  assign rx_pop_s   = rd_s & (idx_s == 3'd0) & ~rx_empty_s;
  assign tx_push_s  = wr_s & (idx_s == 3'd0) & ~tx_full_s;
  assign tov_set_s  = wr_s & (idx_s == 3'd0) & tx_full_s;
  assign rx_flush_s = wr_s & (idx_s == 3'd2) & mem_wdata[1];
  assign tx_flush_s = wr_s & (idx_s == 3'd2) & mem_wdata[2];

  uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .flush(rx_flush_s), .push(rx_push_s), .pop(rx_pop_s),
    .wdata(rx_sh_r), .rdata(rx_head_s), .count(rx_count_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .flush(tx_flush_s), .push(tx_push_s), .pop(tx_pop_s),
    .wdata(mem_wdata[7:0]), .rdata(tx_head_s), .count(tx_count_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  assign rx_cnt9_s = 9'(rx_count_s);
  assign tx_cnt9_s = 9'(tx_count_s);
  assign lvl_s = {(rx_cnt9_s > 9'd15) ? 4'hF : rx_cnt9_s[3:0],
                  (tx_cnt9_s > 9'd15) ? 4'hF : tx_cnt9_s[3:0]};
  assign lsr_s = {tov_r, tx_empty_s & (tx_state_r == ST_IDLE), tx_empty_s, tx_full_s,
                  fe_r, pe_r, oe_r, ~rx_empty_s};

`ifdef UART_IRQ_EN
  logic [2:0] ier_r;
  logic       irq_r;
  assign irq = irq_r;
`endif

  // Read-data multiplexer for the register map.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (idx_s)
      3'd0:    rdata_s = rx_empty_s ? 32'h0000_0000 : {24'h00_0000, rx_head_s};
      3'd1:    rdata_s = 32'(div_r);
      3'd3:    rdata_s = {29'h0000_0000, lcr_r};
`ifdef UART_IRQ_EN
      3'd4:    rdata_s = {29'h0000_0000, ier_r};
`endif
      3'd5:    rdata_s = {24'h00_0000, lsr_s};
      3'd6:    rdata_s = {24'h00_0000, lvl_s};
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // Bus acknowledge and registered read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
    end else begin
      mem_ready_r <= accept_s;
      mem_rdata_r <= rd_s ? rdata_s : 32'h0000_0000;
    end
  end
  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;

  // Configuration registers; divisors below 4 are clamped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_r <= DIV_W'(DEFAULT_DIV);
      lcr_r <= 3'b000;
    end else if (wr_s & (idx_s == 3'd1)) begin
      div_r <= (mem_wdata[DIV_W-1:0] < DIV_W'(4)) ? DIV_W'(4) : mem_wdata[DIV_W-1:0];
    end else if (wr_s & (idx_s == 3'd3)) begin
      lcr_r <= mem_wdata[2:0];
    end
  end

  // Sticky error flags: a new event wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {tov_r, fe_r, pe_r, oe_r} <= 4'b0000;
    end else begin
      if (tov_set_s) tov_r <= 1'b1;
      else if (wr_s & (idx_s == 3'd5) & mem_wdata[7]) tov_r <= 1'b0;
      if (fe_set_s) fe_r <= 1'b1;
      else if (wr_s & (idx_s == 3'd5) & mem_wdata[3]) fe_r <= 1'b0;
      if (pe_set_s) pe_r <= 1'b1;
      else if (wr_s & (idx_s == 3'd5) & mem_wdata[2]) pe_r <= 1'b0;
      if (oe_set_s) oe_r <= 1'b1;
      else if (wr_s & (idx_s == 3'd5) & mem_wdata[1]) oe_r <= 1'b0;
    end
  end

`ifdef UART_IRQ_EN
  // Interrupt enable register and registered interrupt output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ier_r <= 3'b000;
      irq_r <= 1'b0;
    end else begin
      if (wr_s & (idx_s == 3'd4)) ier_r <= mem_wdata[2:0];
      irq_r <= |(ier_r & {tov_r | fe_r | pe_r | oe_r, tx_empty_s, ~rx_empty_s});
    end
  end
`endif

  // The next character is fetched from IDLE or straight out of the last stop bit.
  always_comb begin
    tx_end_s = (tx_state_r == ST_STOP) & (tx_cnt_r == {DIV_W{1'b0}}) & (~tx_stop2_r | tx_stop_sec_r);
    if ((tx_state_r == ST_IDLE) | tx_end_s) tx_pop_s = ~tx_empty_s;
    else                                     tx_pop_s = 1'b0;
  end

  // Transmit FSM; line format and divisor are captured per character.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_r <= ST_IDLE;  tx_bit_r <= 3'd0;  tx_cnt_r <= {DIV_W{1'b0}};
      tx_div_r <= DIV_W'(DEFAULT_DIV);  tx_sh_r <= 8'h00;  tx_par_en_r <= 1'b0;
      tx_stop2_r <= 1'b0;  tx_par_r <= 1'b0;  tx_stop_sec_r <= 1'b0;  txd_r <= 1'b1;
    end else if (tx_pop_s) begin
      tx_state_r <= ST_START;  txd_r <= 1'b0;  tx_cnt_r <= div_r - 1'b1;  tx_div_r <= div_r;
      tx_sh_r <= tx_head_s;  tx_par_r <= parity_bit(tx_head_s, lcr_r[1]);
      tx_par_en_r <= lcr_r[0];  tx_stop2_r <= lcr_r[2];
    end else if ((tx_state_r != ST_IDLE) & (tx_cnt_r != {DIV_W{1'b0}})) begin
      tx_cnt_r <= tx_cnt_r - 1'b1;
    end else begin
      tx_cnt_r <= tx_div_r - 1'b1;
      case (tx_state_r)
        ST_START: begin
          tx_state_r <= ST_DATA;  txd_r <= tx_sh_r[0];
          tx_sh_r <= {1'b0, tx_sh_r[7:1]};  tx_bit_r <= 3'd0;
        end
        ST_DATA: begin
          if (tx_bit_r != 3'd7) begin
            txd_r <= tx_sh_r[0];  tx_sh_r <= {1'b0, tx_sh_r[7:1]};  tx_bit_r <= tx_bit_r + 1'b1;
          end else if (tx_par_en_r) begin
            tx_state_r <= ST_PARITY;  txd_r <= tx_par_r;
          end else begin
            tx_state_r <= ST_STOP;  txd_r <= 1'b1;  tx_stop_sec_r <= 1'b0;
          end
        end
        ST_PARITY: begin
          tx_state_r <= ST_STOP;  txd_r <= 1'b1;  tx_stop_sec_r <= 1'b0;
        end
        ST_STOP: begin
          if (tx_stop2_r & ~tx_stop_sec_r) tx_stop_sec_r <= 1'b1;
          else                             tx_state_r <= ST_IDLE;
        end
        default: begin
          tx_state_r <= ST_IDLE;  txd_r <= 1'b1;
        end
      endcase
    end
  end
  assign uart_txd = txd_r;

  assign rx_done_s = (rx_state_r == ST_STOP) & (rx_cnt_r == {DIV_W{1'b0}});
  assign fe_set_s  = rx_done_s & ~rxd_s2_r;
  assign pe_set_s  = rx_done_s & rxd_s2_r & rx_par_bad_r;
  assign rx_good_s = rx_done_s & rxd_s2_r & ~rx_par_bad_r;
  assign oe_set_s  = rx_good_s & rx_full_s;
  assign rx_push_s = rx_good_s & ~rx_full_s;

  // Receive synchroniser and FSM; bits are sampled mid-period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1_r <= 1'b1;  rxd_s2_r <= 1'b1;  rxd_prev_r <= 1'b1;
      rx_state_r <= ST_IDLE;  rx_bit_r <= 3'd0;  rx_cnt_r <= {DIV_W{1'b0}};
      rx_div_r <= DIV_W'(DEFAULT_DIV);  rx_sh_r <= 8'h00;
      rx_par_en_r <= 1'b0;  rx_even_r <= 1'b0;  rx_par_bad_r <= 1'b0;
    end else begin
      rxd_s1_r <= uart_rxd;  rxd_s2_r <= rxd_s1_r;  rxd_prev_r <= rxd_s2_r;
      if (rx_state_r == ST_IDLE) begin
        if (rxd_prev_r & ~rxd_s2_r) begin
          rx_state_r <= ST_START;  rx_cnt_r <= (div_r >> 1) - 1'b1;  rx_div_r <= div_r;
          rx_par_en_r <= lcr_r[0];  rx_even_r <= lcr_r[1];  rx_par_bad_r <= 1'b0;
        end
      end else if (rx_cnt_r != {DIV_W{1'b0}}) begin
        rx_cnt_r <= rx_cnt_r - 1'b1;
      end else begin
        rx_cnt_r <= rx_div_r - 1'b1;
        case (rx_state_r)
          ST_START: begin
            if (rxd_s2_r) rx_state_r <= ST_IDLE;
            else begin rx_state_r <= ST_DATA; rx_bit_r <= 3'd0; end
          end
          ST_DATA: begin
            rx_sh_r <= {rxd_s2_r, rx_sh_r[7:1]};
            rx_bit_r <= rx_bit_r + 1'b1;
            if (rx_bit_r == 3'd7) rx_state_r <= rx_par_en_r ? ST_PARITY : ST_STOP;
          end
          ST_PARITY: begin
            rx_par_bad_r <= (rxd_s2_r != parity_bit(rx_sh_r, rx_even_r));
            rx_state_r <= ST_STOP;
          end
          default: rx_state_r <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
